// File: rtl/lin_off_cal_if.sv
// AXI4-stream bundle for the signed-sample path: DN lanes of DW bits,
// clock and reset carried in the interface.
interface axi4_stream_if #(
  parameter int DN = 1,
  parameter int DW = 14
) (
  input logic ACLK,
  input logic ARESETn
);
  logic [DN-1:0][DW-1:0] TDATA;
  logic [DN-1:0]         TKEEP;
  logic                  TLAST;
  logic                  TVALID;
  logic                  TREADY;

  modport d (
    input  ACLK, ARESETn,
    input  TDATA, TKEEP, TLAST, TVALID,
    output TREADY
  );

  modport s (
    input  ACLK, ARESETn,
    output TDATA, TKEEP, TLAST, TVALID,
    input  TREADY
  );
endinterface

// File: rtl/lin_off_cal.sv
// Offset calibration sink: averages 2^cfg_log transfers, emits -floor(mean).
// Optional LIN_OFF_CAL_TLAST_EN: frame-align the run on the first TLAST.
module lin_off_cal #(
  parameter int  DN  = 1,
  parameter type DTI = logic signed [14-1:0],
  parameter type DTS = logic signed [15-1:0],
  parameter int  LW  = 5
) (
  axi4_stream_if.d      sti,
  input  logic [LW-1:0] cfg_log,
  input  logic          ctl_start,
  input  logic          ctl_stop,
  output logic          sts_busy,
  output logic          sts_done,
  output DTS            sts_off
);

  localparam int DWI = $bits(DTI);
  localparam int DWS = $bits(DTS);
  localparam int LDN = $clog2(DN);
  localparam int SW  = DWI + LDN;
  localparam int CW  = (1 << LW) - 1;
  localparam int AW  = SW + CW;

  localparam logic signed [AW:0] SMAX =
    {{(AW-DWS+2){1'b0}}, {(DWS-1){1'b1}}};
  localparam logic signed [AW:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CALC,
    ARM
  } state_t;

`ifdef LIN_OFF_CAL_TLAST_EN
  localparam state_t S_GO = ARM;
`else
  localparam state_t S_GO = RUN;
`endif

  logic clk;
  logic rst_n;
  logic transf;

  assign clk        = sti.ACLK;
  assign rst_n      = sti.ARESETn;
  assign sti.TREADY = sti.ARESETn;
  assign transf     = sti.TVALID & sti.TREADY;

`ifdef LIN_OFF_CAL_TLAST_EN
  logic unused_in;
  assign unused_in = ^sti.TKEEP;
`else
  logic unused_in;
  assign unused_in = ^{sti.TKEEP, sti.TLAST};
`endif

  state_t                state_q, state_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [LW-1:0]         log_q, log_d;
  logic signed [SW-1:0]  sum_q, sum_d;
  logic                  sv_q, sv_d;
  logic                  fin_q, fin_d;
  DTS                    off_q, off_d;
  logic                  done_q, done_d;

  logic signed [SW-1:0]  lsum;
  logic signed [DWI-1:0] lane;

  always_comb begin
    lsum = '0;
    lane = '0;
    for (int i = 0; i < DN; i++) begin
      lane = sti.TDATA[i];
      lsum = lsum + SW'(lane);
    end
  end

  logic [CW-1:0]        lim;
  logic [LW:0]          sh;
  logic signed [AW:0]   mx;
  logic signed [AW:0]   negv;
  DTS                   sat;

  always_comb begin
    lim  = ~({CW{1'b1}} << log_q);
    sh   = (LW+1)'(log_q) + (LW+1)'(LDN);
    mx   = (AW+1)'(acc_q >>> sh);
    negv = -mx;
    if (negv > SMAX) begin
      sat = DTS'(SMAX[DWS-1:0]);
    end else if (negv < SMIN) begin
      sat = DTS'(SMIN[DWS-1:0]);
    end else begin
      sat = DTS'(negv[DWS-1:0]);
    end
  end

  // Transfers land in sum_q first; acc absorbs them one cycle later.
  always_comb begin
    logic clr;
    clr     = 1'b0;
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    log_d   = log_q;
    sum_d   = sum_q;
    sv_d    = 1'b0;
    fin_d   = fin_q;
    off_d   = off_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ctl_start) begin
          clr     = 1'b1;
          state_d = S_GO;
        end
      end
`ifdef LIN_OFF_CAL_TLAST_EN
      ARM: begin
        if (ctl_stop) begin
          state_d = IDLE;
        end else if (ctl_start) begin
          clr = 1'b1;
        end else if (transf && sti.TLAST) begin
          state_d = RUN;
        end
      end
`endif
      RUN: begin
        if (ctl_stop) begin
          state_d = IDLE;
          fin_d   = 1'b0;
        end else if (ctl_start) begin
          clr     = 1'b1;
          state_d = S_GO;
        end else begin
          if (sv_q) begin
            acc_d = acc_q + AW'(sum_q);
          end
          if (transf && !fin_q) begin
            sum_d = lsum;
            sv_d  = 1'b1;
            cnt_d = cnt_q + CW'(1);
            fin_d = (cnt_q == lim);
          end
          if (fin_q) begin
            state_d = CALC;
            fin_d   = 1'b0;
          end
        end
      end
      CALC: begin
        off_d   = sat;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
      log_d = cfg_log;
      fin_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      log_q   <= '0;
      sum_q   <= '0;
      sv_q    <= 1'b0;
      fin_q   <= 1'b0;
      off_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      log_q   <= log_d;
      sum_q   <= sum_d;
      sv_q    <= sv_d;
      fin_q   <= fin_d;
      off_q   <= off_d;
      done_q  <= done_d;
    end
  end

  assign sts_busy = (state_q != IDLE);
  assign sts_done = done_q;
  assign sts_off  = off_q;

endmodule

// File: tb/tb_lin_off_cal.sv
// Bench for lin_off_cal: one DN=1 instance (15b offset), one DN=2
// instance (14b offset), random runs against an arithmetic model.
module tb_lin_off_cal;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] cfg_log = '0;
  logic start_a = 1'b0, stop_a = 1'b0;
  logic start_b = 1'b0, stop_b = 1'b0;
  logic busy_a, done_a, busy_b, done_b;
  logic signed [14:0] off_a;
  logic signed [13:0] off_b;

  int n_chk = 0;
  int n_err = 0;
  int dn_a = 0;
  int dn_b = 0;

  typedef struct {
    bit v;
    bit l;
    int x0;
    int x1;
  } item_t;
  item_t tq[$];

  always #5 clk = ~clk;

  axi4_stream_if #(.DN(1), .DW(14)) ia (.ACLK(clk), .ARESETn(rst_n));
  axi4_stream_if #(.DN(2), .DW(14)) ib (.ACLK(clk), .ARESETn(rst_n));

  lin_off_cal #(
    .DN(1), .DTI(logic signed [13:0]),
    .DTS(logic signed [14:0]), .LW(5)
  ) u_a (
    .sti(ia), .cfg_log(cfg_log),
    .ctl_start(start_a), .ctl_stop(stop_a),
    .sts_busy(busy_a), .sts_done(done_a), .sts_off(off_a)
  );

  lin_off_cal #(
    .DN(2), .DTI(logic signed [13:0]),
    .DTS(logic signed [13:0]), .LW(5)
  ) u_b (
    .sti(ib), .cfg_log(cfg_log),
    .ctl_start(start_b), .ctl_stop(stop_b),
    .sts_busy(busy_b), .sts_done(done_b), .sts_off(off_b)
  );

  always @(negedge clk) begin
    if (done_a) dn_a++;
    if (done_b) dn_b++;
  end

  task automatic check(string tag, longint got, longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint fdiv(longint s, longint n);
    longint q = s / n;
    if ((s % n != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint satw(longint v, int w);
    longint mx = (longint'(1) <<< (w - 1)) - 1;
    if (v > mx) return mx;
    if (v < -mx - 1) return -mx - 1;
    return v;
  endfunction

  function automatic int rs();
    if ($urandom_range(7) == 0)
      return ($urandom_range(1) == 1) ? -8192 : 8191;
    return int'($urandom_range(16383)) - 8192;
  endfunction

  function automatic longint o_off(int d);
    if (d == 0) return longint'(off_a);
    return longint'(off_b);
  endfunction

  function automatic longint o_busy(int d);
    return (d == 0) ? longint'(busy_a) : longint'(busy_b);
  endfunction

  function automatic longint o_done(int d);
    return (d == 0) ? longint'(done_a) : longint'(done_b);
  endfunction

  task automatic set_in(int d, bit v, bit l, int x0, int x1);
    if (d == 0) begin
      ia.TVALID = v;
      ia.TLAST = l;
      ia.TKEEP = '1;
      ia.TDATA[0] = 14'(x0);
    end else begin
      ib.TVALID = v;
      ib.TLAST = l;
      ib.TKEEP = '1;
      ib.TDATA[0] = 14'(x0);
      ib.TDATA[1] = 14'(x1);
    end
  endtask

  task automatic set_ctl(int d, bit s, bit p);
    if (d == 0) begin
      start_a = s;
      stop_a = p;
    end else begin
      start_b = s;
      stop_b = p;
    end
  endtask

  task automatic add(bit v, int x0, int x1, bit l);
    item_t it;
    it.v = v;
    it.l = l;
    it.x0 = x0;
    it.x1 = x1;
    tq.push_back(it);
  endtask

  task automatic begin_q(bit arm);
    tq.delete();
`ifdef LIN_OFF_CAL_TLAST_EN
    if (arm) add(1, 0, 0, 1);
`else
    if (arm) tq.delete();
`endif
  endtask

  // Walks the transfer list: frame alignment, N-sample mean, floor, clamp.
  function automatic int model(int d, int lg, output longint e);
    longint s = 0;
    int c = 0;
    int n = 1 << lg;
    bit armed;
`ifdef LIN_OFF_CAL_TLAST_EN
    armed = 1'b0;
`else
    armed = 1'b1;
`endif
    e = 0;
    foreach (tq[k]) begin
      if (tq[k].v) begin
        if (!armed) begin
          if (tq[k].l) armed = 1'b1;
        end else begin
          s += tq[k].x0 + ((d == 1) ? tq[k].x1 : 0);
          c++;
          if (c == n) begin
            e = satw(-fdiv(s, longint'(n) * (d + 1)),
                     (d == 0) ? 15 : 14);
            return k;
          end
        end
      end
    end
    return -1;
  endfunction

  task automatic meas(int d, int lg, bit use_w, longint w, string tag);
    longint e;
    int kf;
    kf = model(d, lg, e);
    if (use_w) e = w;
    if (kf < 0) begin
      check({tag, "_stim_len"}, kf, 0);
      return;
    end
    @(negedge clk);
    cfg_log = 5'(lg);
    set_ctl(d, 1, 0);
    set_in(d, 1, 0, rs(), rs());
    @(negedge clk);
    set_ctl(d, 0, 0);
    cfg_log = 5'($urandom);
    for (int k = 0; k <= kf; k++) begin
      set_in(d, tq[k].v, tq[k].l, tq[k].x0, tq[k].x1);
      @(negedge clk);
    end
    set_in(d, 1, 0, rs(), rs());
    check({tag, "_busy_e0"}, o_busy(d), 1);
    check({tag, "_done_e0"}, o_done(d), 0);
    @(negedge clk);
    set_in(d, 1, 0, rs(), rs());
    check({tag, "_busy_e1"}, o_busy(d), 1);
    check({tag, "_done_e1"}, o_done(d), 0);
    @(negedge clk);
    set_in(d, 0, 0, 0, 0);
    check({tag, "_done_e2"}, o_done(d), 1);
    check({tag, "_off"}, o_off(d), e);
    check({tag, "_busy_e2"}, o_busy(d), 0);
    @(negedge clk);
    check({tag, "_done_e3"}, o_done(d), 0);
  endtask

  task automatic feed(int d, int x, int n);
    for (int k = 0; k < n; k++) begin
      set_in(d, 1, 0, x, x);
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int snap;
    set_in(0, 0, 0, 0, 0);
    set_in(1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_tready", longint'(ia.TREADY), 0);
    check("rst_off", o_off(0), 0);
    check("rst_busy", o_busy(0), 0);
    check("rst_done", o_done(0), 0);
    rst_n = 1'b1;
    #1;
    check("tready_on", longint'(ia.TREADY), 1);

    begin_q(1);
    add(1, 10, 0, 0); add(1, 12, 0, 0);
    add(1, 14, 0, 0); add(1, 16, 0, 0);
    meas(0, 2, 1, -13, "basic");

    begin_q(1);
    add(1, -1, 0, 0); add(1, -2, 0, 0);
    add(1, -2, 0, 0); add(1, -2, 0, 0);
    meas(0, 2, 1, 2, "floor");

    begin_q(1);
    add(0, 99, 0, 0); add(1, -1, 0, 0); add(0, 5, 0, 0);
    add(1, -2, 0, 0); add(0, 7, 0, 0); add(0, 7, 0, 0);
    add(1, -2, 0, 0); add(1, -2, 0, 0);
    meas(0, 2, 1, 2, "floor_gap");

    begin_q(1);
    add(1, 1234, 0, 0);
    meas(0, 0, 1, -1234, "log0");

    begin_q(1);
    for (int k = 0; k < 8; k++) add(1, -8192, 0, 0);
    meas(0, 3, 1, 8192, "wide_min");

    begin_q(1);
    for (int k = 0; k < 8; k++) add(1, -8192, -8192, 0);
    meas(1, 3, 1, 8191, "sat_min");

    begin_q(1);
    for (int k = 0; k < 8; k++) add(1, 8191, 8191, 0);
    meas(1, 3, 1, -8191, "sat_max");

    begin_q(0);
    add(1, 100, 100, 0); add(1, 7, 7, 1);
    add(1, 4, 6, 0); add(1, 8, 10, 0);
`ifdef LIN_OFF_CAL_TLAST_EN
    meas(1, 1, 1, -7, "lanes");
`else
    meas(1, 1, 1, -53, "lanes");
`endif

    begin_q(1);
    for (int k = 0; k < 4; k++) add(1, -5, 0, 0);
    meas(0, 2, 1, 5, "pre5");

    snap = dn_a;
    @(negedge clk);
    cfg_log = 5'd2;
    set_ctl(0, 1, 0);
    @(negedge clk);
    set_ctl(0, 0, 0);
    feed(0, -100, 2);
    set_in(0, 0, 0, 0, 0);
    set_ctl(0, 0, 1);
    @(negedge clk);
    set_ctl(0, 0, 0);
    check("stop_busy", o_busy(0), 0);
    feed(0, -100, 6);
    set_in(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("stop_off", o_off(0), 5);
    check("stop_nodone", dn_a - snap, 0);

    @(negedge clk);
    cfg_log = 5'd2;
    set_ctl(0, 1, 0);
    @(negedge clk);
    set_ctl(0, 0, 0);
    feed(0, 4000, 2);
    begin_q(1);
    add(1, 1, 0, 0); add(1, 2, 0, 0);
    add(1, 3, 0, 0); add(1, 4, 0, 0);
    meas(0, 2, 1, -2, "restart");

    snap = dn_a;
    @(negedge clk);
    cfg_log = 5'd2;
    set_ctl(0, 1, 0);
    @(negedge clk);
    set_ctl(0, 0, 0);
    feed(0, 50, 1);
    set_ctl(0, 1, 1);
    feed(0, 50, 1);
    set_ctl(0, 0, 0);
    check("both_busy", o_busy(0), 0);
    feed(0, 50, 6);
    set_in(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("both_nodone", dn_a - snap, 0);
    check("both_off", o_off(0), -2);

    snap = dn_a;
    @(negedge clk);
    cfg_log = 5'd2;
    set_ctl(0, 1, 0);
    @(negedge clk);
    set_ctl(0, 0, 0);
    feed(0, 300, 3);
    set_in(0, 1, 0, 300, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tready", longint'(ia.TREADY), 0);
    @(negedge clk);
    check("mid_rst_off", o_off(0), 0);
    check("mid_rst_busy", o_busy(0), 0);
    check("mid_rst_done", o_done(0), 0);
    rst_n = 1'b1;
    feed(0, 300, 8);
    set_in(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("mid_rst_nodone", dn_a - snap, 0);
    check("mid_rst_busy2", o_busy(0), 0);

    for (int i = 0; i < 24; i++) begin
      int d;
      int lg;
      d = i % 2;
      lg = (d == 0) ? int'($urandom_range(4)) : int'($urandom_range(3));
      tq.delete();
      repeat ((1 << lg) * 4 + 40)
        add($urandom_range(3) != 0, rs(), rs(), $urandom_range(7) == 0);
      meas(d, lg, 0, 0, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
